lcd_hex_string_formatter: RTL and testbench
===========================================

# lcd_hex_string_formatter

Sequential hex-string serializer for the two-line LCD text path: accepts a parametrised-width binary value, then streams its ASCII hexadecimal characters most-significant nibble first, one character per handshake. Supports per-request uppercase/lowercase selection and leading-zero blanking with spaces, so field width stays fixed for LCD alignment. Sits between status/counter logic and the LCD line-buffer writer, replacing per-digit combinational conversion at each call site.

## Interface
- PARM_NIBBLES, 8, number of hex digits per request; legal range 1..16
- i_clk_20mhz  in  1  system clock
- i_rst_20mhz  in  1  reset, synchronous, active-high
- i_start_valid  in  1  request strobe; value and mode inputs are valid
- o_start_ready  out  1  formatter idle and able to accept a request
- i_value  in  4*PARM_NIBBLES  value to format
- i_lowercase  in  1  1: digits A-F emitted as 'a'-'f' (8'h61-8'h66)
- i_blank_zeros  in  1  1: leading zero digits emitted as space (8'h20)
- o_char_valid  out  1  o_char holds a character
- i_char_ready  in  1  downstream accepts o_char this cycle
- o_char  out  8  ASCII character
- o_char_last  out  1  qualifies the final character of the request

## Operation
- States: IDLE, EMIT. Reset enters IDLE.
- IDLE: o_start_ready=1. On i_start_valid&&o_start_ready: latch i_value into shift register, latch both mode bits, load digit index to PARM_NIBBLES-1, load o_char with the MS digit, set o_char_valid, go EMIT.
- EMIT: o_start_ready=0; i_start_valid ignored. On o_char_valid&&i_char_ready: if o_char_last, clear o_char_valid, go IDLE; else shift to next nibble, decrement index, load next character.
- o_char, o_char_valid, o_char_last held stable while valid and not ready.
- o_char_last=1 exactly when index==0.
- Digit mapping: 0-9 -> 8'h30+d; 10-15 -> 8'h37+d (upper) or 8'h57+d (lower).
- Blanking: "seen nonzero" flag cleared on accept, set once any emitted nibble is nonzero. Character is 8'h20 when i_blank_zeros latched, flag clear, nibble==0, index!=0. Index-0 digit is never blanked: value 0 yields spaces then '0'.
- Mode inputs and i_value sampled only at accept; changes during EMIT have no effect.
- Index width: $clog2(PARM_NIBBLES), minimum 1 bit.

## Timing
- Reset values: o_start_ready=0, o_char_valid=0, o_char=8'h20, o_char_last=0; o_start_ready registered, rises the first cycle after reset deasserts.
- Reset mid-EMIT: abandon request that cycle; next cycle outputs equal reset values; no partial string resumes.
- Accept at cycle T: first character valid at T+1. With i_char_ready held high, characters on T+1..T+PARM_NIBBLES, last at T+PARM_NIBBLES, o_start_ready=1 at T+PARM_NIBBLES+1.
- No back-to-back overlap: next accept earliest at T+PARM_NIBBLES+1.
- Throughput one character per cycle under continuous ready; stalls add cycles one-for-one.
- All outputs registered; no combinational path from i_char_ready or i_start_valid to any output.

## Structure
- lcd_text_functions_pkg gains: function ascii_of_hdigit_case(nibble, lowercase) returning 8-bit ASCII (existing uppercase conversion kept unchanged); localparam ASCII_SPACE=8'h20; typedef enum t_hexfmt_state {ST_HEXFMT_IDLE, ST_HEXFMT_EMIT}.
- No sub-module: single always_ff state/datapath block plus an always_comb next-character computation calling the package function.

## Test plan
- PARM_NIBBLES=8, value 32'hDEADBEEF, upper, no blank, ready high -> "DEADBEEF" on 8 consecutive cycles, last on 'F', ready returns next cycle.
- Same value, i_lowercase=1 -> "deadbeef" (8'h64,8'h65,8'h61,...).
- value 32'h000000A0, blank=1 -> six 8'h20, then 'A', '0'; value 0, blank=1 -> seven spaces then '0' with last.
- Random i_char_ready deassertion over 32'h12345678 -> characters held stable while stalled, exact sequence "12345678", no drops or duplicates; i_start_valid pulses during EMIT ignored.
- Reset asserted on third character -> next cycle o_char_valid=0, o_char=8'h20, o_start_ready=0, then 1; fresh request 32'h0000FFFF formats correctly.
- PARM_NIBBLES=1, values 4'h0..4'hF -> single character each with last=1, '0'..'9','A'..'F'.

Source files
------------

// File: rtl/lcd_text_functions_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lcd_text_functions_pkg : shared ASCII helpers and types for the LCD text path
// Revision: 1.1 - adds case-selectable hex digit conversion and hexfmt FSM type
// ---------------------------------------------------------------------------
package lcd_text_functions_pkg;

    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [0:0] {
        ST_HEXFMT_IDLE = 1'b0,
        ST_HEXFMT_EMIT = 1'b1
    } t_hexfmt_state;

    function automatic logic [7:0] ascii_of_hdigit(input logic [3:0] nibble);
        logic [7:0] result;
        if (nibble < 4'd10) result = 8'h30 + {4'h0, nibble};
        else                result = 8'h37 + {4'h0, nibble};
        return result;
    endfunction

    function automatic logic [7:0] ascii_of_hdigit_case(input logic [3:0] nibble,
                                                        input logic       lowercase);
        logic [7:0] result;
        result = ascii_of_hdigit(nibble);
        if (lowercase && (nibble >= 4'd10)) result = 8'h57 + {4'h0, nibble};
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_hex_string_formatter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lcd_hex_string_formatter : streams a binary value as ASCII hex, MS nibble first
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module lcd_hex_string_formatter
    import lcd_text_functions_pkg::*;
#(
    parameter int PARM_NIBBLES = 8
) (
    input  logic                      i_clk_20mhz,
    input  logic                      i_rst_20mhz,
    input  logic                      i_start_valid,
    output logic                      o_start_ready,
    input  logic [4*PARM_NIBBLES-1:0] i_value,
    input  logic                      i_lowercase,
    input  logic                      i_blank_zeros,
    output logic                      o_char_valid,
    input  logic                      i_char_ready,
    output logic [7:0]                o_char,
    output logic                      o_char_last
);

    localparam int VALUE_W = 4 * PARM_NIBBLES;
    localparam int IDX_W   = (PARM_NIBBLES > 1) ? $clog2(PARM_NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(PARM_NIBBLES - 1);

    t_hexfmt_state        state_q, state_d;
    logic [VALUE_W-1:0]   shreg_q, shreg_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 lower_q, lower_d;
    logic                 blank_q, blank_d;
    logic                 seen_q, seen_d;
    logic                 start_ready_q, start_ready_d;
    logic                 char_valid_q, char_valid_d;
    logic [7:0]           char_q, char_d;
    logic                 char_last_q, char_last_d;

    logic                 w_accept;
    logic                 w_advance;
    logic [3:0]           w_next_nib;

    assign w_accept  = i_start_valid && start_ready_q;
    assign w_advance = char_valid_q && i_char_ready;

    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            state_q       <= ST_HEXFMT_IDLE;
            shreg_q       <= '0;
            idx_q         <= '0;
            lower_q       <= 1'b0;
            blank_q       <= 1'b0;
            seen_q        <= 1'b0;
            start_ready_q <= 1'b0;
            char_valid_q  <= 1'b0;
            char_q        <= ASCII_SPACE;
            char_last_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            idx_q         <= idx_d;
            lower_q       <= lower_d;
            blank_q       <= blank_d;
            seen_q        <= seen_d;
            start_ready_q <= start_ready_d;
            char_valid_q  <= char_valid_d;
            char_q        <= char_d;
            char_last_q   <= char_last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HEXFMT_IDLE: if (w_accept) state_d = ST_HEXFMT_EMIT;
            ST_HEXFMT_EMIT: if (w_advance && char_last_q) state_d = ST_HEXFMT_IDLE;
            default:        state_d = ST_HEXFMT_IDLE;
        endcase
    end

    // seen_q covers nibbles already emitted before the one currently on o_char
    always_comb begin
        shreg_d      = shreg_q;
        idx_d        = idx_q;
        lower_d      = lower_q;
        blank_d      = blank_q;
        seen_d       = seen_q;
        char_valid_d = char_valid_q;
        char_d       = char_q;
        char_last_d  = char_last_q;

        if (w_accept) begin
            shreg_d = i_value;
            idx_d   = IDX_FIRST;
            lower_d = i_lowercase;
            blank_d = i_blank_zeros;
            seen_d  = 1'b0;
        end else if (w_advance && !char_last_q) begin
            shreg_d = shreg_q << 4;
            idx_d   = idx_q - 1'b1;
            seen_d  = seen_q || (shreg_q[VALUE_W-1 -: 4] != 4'h0);
        end

        w_next_nib = shreg_d[VALUE_W-1 -: 4];

        if (w_accept || (w_advance && !char_last_q)) begin
            char_valid_d = 1'b1;
            char_last_d  = (idx_d == '0);
            if (blank_d && !seen_d && (w_next_nib == 4'h0) && (idx_d != '0))
                char_d = ASCII_SPACE;
            else
                char_d = ascii_of_hdigit_case(w_next_nib, lower_d);
        end else if (w_advance) begin
            char_valid_d = 1'b0;
            char_last_d  = 1'b0;
        end

        start_ready_d = (state_d == ST_HEXFMT_IDLE);
    end

    assign o_start_ready = start_ready_q;
    assign o_char_valid  = char_valid_q;
    assign o_char        = char_q;
    assign o_char_last   = char_last_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_hex_string_formatter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lcd_hex_string_formatter : self-checking bench, 8-nibble and 1-nibble DUTs
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_lcd_hex_string_formatter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          errors = 0;
    int          checks = 0;

    logic        sv8 = 0, sr8, lo8 = 0, bl8 = 0, cv8, cr8 = 1, cl8;
    logic [31:0] val8 = '0;
    logic [7:0]  ch8;

    logic        sv1 = 0, sr1, lo1 = 0, bl1 = 0, cv1, cr1 = 1, cl1;
    logic [3:0]  val1 = '0;
    logic [7:0]  ch1;

    always #25 clk = ~clk;

    lcd_hex_string_formatter #(.PARM_NIBBLES(8)) dut8 (
        .i_clk_20mhz(clk), .i_rst_20mhz(rst),
        .i_start_valid(sv8), .o_start_ready(sr8),
        .i_value(val8), .i_lowercase(lo8), .i_blank_zeros(bl8),
        .o_char_valid(cv8), .i_char_ready(cr8), .o_char(ch8), .o_char_last(cl8)
    );

    lcd_hex_string_formatter #(.PARM_NIBBLES(1)) dut1 (
        .i_clk_20mhz(clk), .i_rst_20mhz(rst),
        .i_start_valid(sv1), .o_start_ready(sr1),
        .i_value(val1), .i_lowercase(lo1), .i_blank_zeros(bl1),
        .o_char_valid(cv1), .i_char_ready(cr1), .o_char(ch1), .o_char_last(cl1)
    );

    // Character k (0 = first emitted) of an n-digit rendering of v
    function automatic logic [7:0] exp_char(input logic [63:0] v, input int n,
                                            input int k, input bit lo, input bit bl);
        int          i;
        logic [63:0] d;
        bit          seen;
        i    = n - 1 - k;
        d    = (v >> (4 * i)) & 64'hF;
        seen = ((v >> (4 * (i + 1))) != 64'h0);
        if (bl && !seen && d == 64'h0 && i != 0) return 8'h20;
        if (d < 64'd10) return 8'h30 + d[7:0];
        return (lo ? 8'h61 : 8'h41) + d[7:0] - 8'd10;
    endfunction

    task automatic run8(input logic [31:0] v, input bit lo, input bit bl,
                        input bit stall, input bit poke, input string tag);
        int t, got, cyc;
        bit take;
        logic [7:0] want;
        t = 0;
        while (sr8 !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        checks++;
        if (sr8 !== 1'b1) begin
            errors++;
            $display("FAIL %s start_ready before request: got %b want 1", tag, sr8);
            return;
        end
        sv8 = 1; val8 = v; lo8 = lo; bl8 = bl;
        cr8 = stall ? 1'($urandom % 2) : 1'b1;
        @(posedge clk); #1;
        sv8 = 0; val8 = $urandom; lo8 = ~lo; bl8 = ~bl;
        got = 0; cyc = 0;
        while (got < 8 && cyc < 200) begin
            want = exp_char({32'h0, v}, 8, got, lo, bl);
            checks++;
            if (cv8 !== 1'b1 || ch8 !== want || cl8 !== (got == 7)) begin
                errors++;
                $display("FAIL %s char%0d: got valid=%b char=%h last=%b want valid=1 char=%h last=%b",
                         tag, got, cv8, ch8, cl8, want, (got == 7));
            end
            take = cr8;
            sv8 = poke ? 1'($urandom % 2) : 1'b0;
            @(posedge clk); #1;
            cyc++;
            if (take) got++;
            cr8 = stall ? 1'($urandom % 2) : 1'b1;
        end
        sv8 = 0; cr8 = 1;
        if (!stall) begin
            checks++;
            if (cyc != 8) begin
                errors++;
                $display("FAIL %s cycle count: got %0d want 8", tag, cyc);
            end
        end
        checks++;
        if (sr8 !== 1'b1 || cv8 !== 1'b0) begin
            errors++;
            $display("FAIL %s end state: got ready=%b valid=%b want ready=1 valid=0", tag, sr8, cv8);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sr8 !== 1'b0 || cv8 !== 1'b0 || ch8 !== 8'h20 || cl8 !== 1'b0) begin
            errors++;
            $display("FAIL reset8: got ready=%b valid=%b char=%h last=%b want 0 0 20 0", sr8, cv8, ch8, cl8);
        end
        checks++;
        if (sr1 !== 1'b0 || cv1 !== 1'b0 || ch1 !== 8'h20 || cl1 !== 1'b0) begin
            errors++;
            $display("FAIL reset1: got ready=%b valid=%b char=%h last=%b want 0 0 20 0", sr1, cv1, ch1, cl1);
        end
        rst = 0;
        @(posedge clk); #1;
        checks++;
        if (sr8 !== 1'b1 || sr1 !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b/%b want 1/1", sr8, sr1);
        end
    endtask

    task automatic test_patterns();
        run8(32'hDEADBEEF, 0, 0, 0, 0, "upper");
        run8(32'hDEADBEEF, 1, 0, 0, 0, "lower");
        run8(32'h000000A0, 0, 1, 0, 0, "blank_a0");
        run8(32'h00000000, 0, 1, 0, 0, "blank_zero");
        run8(32'h00000000, 1, 0, 0, 0, "zero_noblank");
    endtask

    task automatic test_stall();
        run8(32'h12345678, 0, 0, 1, 1, "stall");
        run8(32'h00C0FFEE, 1, 1, 1, 1, "stall_blank");
    endtask

    task automatic test_reset_mid();
        int t;
        t = 0;
        while (sr8 !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        sv8 = 1; val8 = 32'h12345678; lo8 = 0; bl8 = 0; cr8 = 1;
        @(posedge clk); #1;
        sv8 = 0;
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (cv8 !== 1'b1 || ch8 !== 8'h33) begin
            errors++;
            $display("FAIL mid third_char: got valid=%b char=%h want 1 33", cv8, ch8);
        end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        checks++;
        if (cv8 !== 1'b0 || ch8 !== 8'h20 || sr8 !== 1'b0 || cl8 !== 1'b0) begin
            errors++;
            $display("FAIL mid reset: got valid=%b char=%h ready=%b last=%b want 0 20 0 0", cv8, ch8, sr8, cl8);
        end
        @(posedge clk); #1;
        checks++;
        if (sr8 !== 1'b1 || cv8 !== 1'b0) begin
            errors++;
            $display("FAIL mid ready_return: got ready=%b valid=%b want 1 0", sr8, cv8);
        end
        run8(32'h0000FFFF, 0, 0, 0, 0, "after_reset");
        run8(32'h0000FFFF, 1, 1, 0, 0, "after_reset_bl");
    endtask

    task automatic test_single();
        bit lo, bl;
        int t;
        logic [7:0] want;
        for (int v = 0; v < 16; v++) begin
            lo = 1'($urandom % 2); bl = 1'($urandom % 2);
            t = 0;
            while (sr1 !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
            sv1 = 1; val1 = 4'(v); lo1 = lo; bl1 = bl; cr1 = 1;
            @(posedge clk); #1;
            sv1 = 0; val1 = 4'($urandom);
            want = exp_char(64'(v), 1, 0, lo, bl);
            checks++;
            if (cv1 !== 1'b1 || ch1 !== want || cl1 !== 1'b1) begin
                errors++;
                $display("FAIL single %0d: got valid=%b char=%h last=%b want 1 %h 1", v, cv1, ch1, cl1, want);
            end
            @(posedge clk); #1;
            checks++;
            if (cv1 !== 1'b0 || sr1 !== 1'b1) begin
                errors++;
                $display("FAIL single_end %0d: got valid=%b ready=%b want 0 1", v, cv1, sr1);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 32'($urandom) >> ($urandom % 32);
            run8(v, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), "random");
        end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_stall();
        test_reset_mid();
        test_single();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
